// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle core: opcode encodings and
// the fetch sequencer state type.
package cpu_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    ACK,
    HALTED
  } seq_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-pc resolution for sequential, BEQ, JMP and HALT flow.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 3
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      op,
  input  logic [6:0]      imm,
  input  logic            zero_flag,
  output logic [PC_W-1:0] next_pc,
  output logic            is_halt
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] imm_pc;

  assign pc_inc = pc + PC_W'(1);
  // Only the low PC_W immediate bits address the instruction memory; the
  // truncation also makes the BEQ offset a PC_W-bit two's-complement value.
  assign imm_pc = imm[PC_W-1:0];

  generate
    if (PC_W < 7) begin : g_imm_unused
      logic imm_high_unused;
      assign imm_high_unused = ^imm[6:PC_W];
    end
  endgenerate

  always_comb begin
    next_pc = pc_inc;
    is_halt = 1'b0;
    case (op)
      OP_HALT: begin
        next_pc = pc;
        is_halt = 1'b1;
      end
      OP_JMP: next_pc = imm_pc;
      OP_BEQ: if (zero_flag) next_pc = pc_inc + imm_pc;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side pc sequencer: free-run / single-step control, stall hold,
// halt detection and a saturating retired-instruction counter.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W     = 3,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             stall,
  input  logic [2:0]       instr_op,
  input  logic [6:0]       instr_imm,
  input  logic             zero_flag,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);

  seq_state_t       state;
  logic             ack_pending;
  logic [PC_W-1:0]  next_pc;
  logic             is_halt;
  logic [CNT_W-1:0] cnt_inc;
  logic             start_ok;

  pc_next_calc #(.PC_W(PC_W)) u_next (
    .pc        (pc),
    .op        (instr_op),
    .imm       (instr_imm),
    .zero_flag (zero_flag),
    .next_pc   (next_pc),
    .is_halt   (is_halt)
  );

  assign cnt_inc  = (retired_cnt == {CNT_W{1'b1}}) ? retired_cnt : retired_cnt + CNT_W'(1);
  assign start_ok = start && !stop;

  assign pc_valid = (state == RUN) || (state == STEP);
  assign halted   = (state == HALTED);
  // A step that lands on HALT still owes the requester its acknowledge.
  assign step_ack = (state == ACK) || ((state == HALTED) && ack_pending);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= START_PC;
      retired_cnt <= '0;
      ack_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state       <= RUN;
            pc          <= START_PC;
            retired_cnt <= '0;
          end else if (step_req && !step_ack) begin
            state <= STEP;
          end
        end
        RUN: begin
          if (!stall) begin
            retired_cnt <= cnt_inc;
            pc          <= next_pc;
            if (is_halt)   state <= HALTED;
            else if (stop) state <= IDLE;
          end
        end
        STEP: begin
          if (!stall) begin
            retired_cnt <= cnt_inc;
            pc          <= next_pc;
            if (is_halt) begin
              state       <= HALTED;
              ack_pending <= 1'b1;
            end else begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          if (!step_req) state <= IDLE;
        end
        HALTED: begin
          if (!step_req) ack_pending <= 1'b0;
          if (start_ok) begin
            state       <= RUN;
            pc          <= START_PC;
            retired_cnt <= '0;
            ack_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; a small program table feeds
// instr_op/instr_imm from the current pc.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam int PC_W  = 3;
  localparam int CNT_W = 4;
  localparam logic [2:0] OP_NOP = 3'b000;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             step_req;
  logic             step_ack;
  logic             stall;
  logic [2:0]       instr_op;
  logic [6:0]       instr_imm;
  logic             zero_flag;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             halted;
  logic [CNT_W-1:0] retired_cnt;

  logic [2:0] prog_op  [8];
  logic [6:0] prog_imm [8];

  int n_checks = 0;
  int n_fail   = 0;

  assign instr_op  = prog_op[pc];
  assign instr_imm = prog_imm[pc];

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .stall       (stall),
    .instr_op    (instr_op),
    .instr_imm   (instr_imm),
    .zero_flag   (zero_flag),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 8; i++) begin
      prog_op[i]  = OP_NOP;
      prog_imm[i] = 7'd0;
    end
  endtask

  task automatic do_step();
    step_req = 1'b1;
    cyc();
    cyc();
    step_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    load_nops();
    rst = 1'b0; start = 1'b0; stop = 1'b0; step_req = 1'b0; stall = 1'b0; zero_flag = 1'b0;
    cyc(); cyc();
    n_checks++; if (pc !== 3'd0) begin n_fail++; $display("FAIL reset_pc actual=%0d required=0", pc); end
    n_checks++; if (pc_valid !== 1'b0 || halted !== 1'b0 || step_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags actual=%b%b%b required=000", pc_valid, halted, step_ack); end
    n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt actual=%0d required=0", retired_cnt); end
    rst = 1'b1;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (5) cyc();
    n_checks++; if (pc !== 3'd5 || retired_cnt !== 4'd5) begin
      n_fail++; $display("FAIL prereset_run actual pc=%0d cnt=%0d required pc=5 cnt=5", pc, retired_cnt); end
    #3 rst = 1'b0;
    #1;
    n_checks++; if (pc !== 3'd0 || pc_valid !== 1'b0 || retired_cnt !== 4'd0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL async_reset actual pc=%0d valid=%b cnt=%0d halted=%b required 0 0 0 0",
                         pc, pc_valid, retired_cnt, halted); end
    cyc(); rst = 1'b1; cyc();
    $display("test_reset done pc=%0d", pc);
  endtask

  task automatic test_wrap();
    load_nops();
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (pc !== 3'd0 || pc_valid !== 1'b1 || retired_cnt !== 4'd0) begin
      n_fail++; $display("FAIL wrap_start actual pc=%0d valid=%b cnt=%0d required 0 1 0", pc, pc_valid, retired_cnt); end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_checks++; if (pc !== 3'(i % 8)) begin
        n_fail++; $display("FAIL wrap_pc step=%0d actual=%0d required=%0d", i, pc, i % 8); end
    end
    n_checks++; if (retired_cnt !== 4'd8) begin n_fail++; $display("FAIL wrap_cnt actual=%0d required=8", retired_cnt); end
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc();
    n_checks++; if (pc !== 3'd1 || pc_valid !== 1'b0 || retired_cnt !== 4'd9) begin
      n_fail++; $display("FAIL stop_hold actual pc=%0d valid=%b cnt=%0d required 1 0 9", pc, pc_valid, retired_cnt); end
    $display("test_wrap done pc=%0d cnt=%0d", pc, retired_cnt);
  endtask

  task automatic test_branch();
    load_nops();
    prog_op[2] = OP_BEQ; prog_imm[2] = 7'h7E;
    prog_op[6] = OP_JMP; prog_imm[6] = 7'd3;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    zero_flag = 1'b1; cyc();
    cyc();
    n_checks++; if (pc !== 3'd1) begin n_fail++; $display("FAIL beq_taken actual=%0d required=1", pc); end
    zero_flag = 1'b0; cyc();
    cyc();
    n_checks++; if (pc !== 3'd3) begin n_fail++; $display("FAIL beq_not_taken actual=%0d required=3", pc); end
    cyc(); cyc(); cyc();
    n_checks++; if (pc !== 3'd6) begin n_fail++; $display("FAIL pre_jmp actual=%0d required=6", pc); end
    cyc();
    n_checks++; if (pc !== 3'd3) begin n_fail++; $display("FAIL jmp actual=%0d required=3", pc); end
    n_checks++; if (retired_cnt !== 4'd9) begin n_fail++; $display("FAIL branch_cnt actual=%0d required=9", retired_cnt); end
    stop = 1'b1; cyc(); stop = 1'b0;
    $display("test_branch done pc=%0d", pc);
  endtask

  task automatic test_stall();
    load_nops();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (pc !== 3'd4 || retired_cnt !== 4'd4 || pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold cycle=%0d actual pc=%0d cnt=%0d valid=%b required 4 4 1",
                           i, pc, retired_cnt, pc_valid); end
    end
    stall = 1'b0; cyc();
    n_checks++; if (pc !== 3'd5 || retired_cnt !== 4'd5) begin
      n_fail++; $display("FAIL stall_release actual pc=%0d cnt=%0d required 5 5", pc, retired_cnt); end
    stop = 1'b1; cyc(); stop = 1'b0;
    n_checks++; if (pc !== 3'd6 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_stop actual pc=%0d valid=%b required 6 0", pc, pc_valid); end
    $display("test_stall done pc=%0d", pc);
  endtask

  task automatic test_step();
    step_req = 1'b1; cyc();
    n_checks++; if (pc !== 3'd6 || pc_valid !== 1'b1 || step_ack !== 1'b0) begin
      n_fail++; $display("FAIL step_enter actual pc=%0d valid=%b ack=%b required 6 1 0", pc, pc_valid, step_ack); end
    cyc();
    n_checks++; if (pc !== 3'd7 || step_ack !== 1'b1 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL step_retire actual pc=%0d ack=%b valid=%b required 7 1 0", pc, step_ack, pc_valid); end
    cyc();
    n_checks++; if (pc !== 3'd7 || step_ack !== 1'b1) begin
      n_fail++; $display("FAIL step_ack_hold actual pc=%0d ack=%b required 7 1", pc, step_ack); end
    step_req = 1'b0; cyc();
    n_checks++; if (step_ack !== 1'b0 || pc !== 3'd7) begin
      n_fail++; $display("FAIL step_ack_release actual ack=%b pc=%0d required 0 7", step_ack, pc); end
    step_req = 1'b1; stall = 1'b1; cyc(); cyc();
    n_checks++; if (pc !== 3'd7 || step_ack !== 1'b0 || pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL step_stall actual pc=%0d ack=%b valid=%b required 7 0 1", pc, step_ack, pc_valid); end
    stall = 1'b0; cyc();
    n_checks++; if (pc !== 3'd0 || step_ack !== 1'b1) begin
      n_fail++; $display("FAIL step_wrap actual pc=%0d ack=%b required 0 1", pc, step_ack); end
    step_req = 1'b0; cyc();
    step_req = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (pc_valid !== 1'b1 || step_ack !== 1'b0 || pc !== 3'd0 || retired_cnt !== 4'd0) begin
      n_fail++; $display("FAIL start_beats_step actual valid=%b ack=%b pc=%0d cnt=%0d required 1 0 0 0",
                         pc_valid, step_ack, pc, retired_cnt); end
    cyc();
    n_checks++; if (pc !== 3'd1 || step_ack !== 1'b0 || pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL stray_step_in_run actual pc=%0d ack=%b valid=%b required 1 0 1", pc, step_ack, pc_valid); end
    step_req = 1'b0; stop = 1'b1; cyc(); stop = 1'b0;
    $display("test_step done pc=%0d", pc);
  endtask

  task automatic test_halt();
    load_nops();
    prog_op[3] = OP_HALT;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++; if (pc !== 3'd3 || retired_cnt !== 4'd3) begin
      n_fail++; $display("FAIL pre_halt actual pc=%0d cnt=%0d required 3 3", pc, retired_cnt); end
    cyc();
    n_checks++; if (halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 3'd3 || retired_cnt !== 4'd4) begin
      n_fail++; $display("FAIL halt_enter actual halted=%b valid=%b pc=%0d cnt=%0d required 1 0 3 4",
                         halted, pc_valid, pc, retired_cnt); end
    cyc();
    n_checks++; if (pc !== 3'd3 || retired_cnt !== 4'd4 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_frozen actual pc=%0d cnt=%0d halted=%b required 3 4 1", pc, retired_cnt, halted); end
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (pc !== 3'd0 || retired_cnt !== 4'd0 || halted !== 1'b0 || pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart actual pc=%0d cnt=%0d halted=%b valid=%b required 0 0 0 1",
                         pc, retired_cnt, halted, pc_valid); end
    stop = 1'b1; cyc(); stop = 1'b0;
    do_step();
    do_step();
    step_req = 1'b1; cyc(); cyc();
    n_checks++; if (halted !== 1'b1 || step_ack !== 1'b1 || pc !== 3'd3 || retired_cnt !== 4'd4) begin
      n_fail++; $display("FAIL step_halt actual halted=%b ack=%b pc=%0d cnt=%0d required 1 1 3 4",
                         halted, step_ack, pc, retired_cnt); end
    cyc();
    n_checks++; if (step_ack !== 1'b1) begin n_fail++; $display("FAIL step_halt_ack_hold actual=%b required=1", step_ack); end
    step_req = 1'b0; cyc();
    n_checks++; if (step_ack !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL step_halt_release actual ack=%b halted=%b required 0 1", step_ack, halted); end
    $display("test_halt done pc=%0d cnt=%0d", pc, retired_cnt);
  endtask

  task automatic test_saturate();
    load_nops();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (20) cyc();
    n_checks++; if (retired_cnt !== 4'd15 || pc !== 3'd4) begin
      n_fail++; $display("FAIL cnt_saturate actual cnt=%0d pc=%0d required 15 4", retired_cnt, pc); end
    stop = 1'b1; cyc(); stop = 1'b0;
    $display("test_saturate done cnt=%0d", retired_cnt);
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_stall();
    test_step();
    test_halt();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
